// File: rtl/digit_inc_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : digit_inc_scheduler
// Purpose  : Walks one shared digit adder across a multi-digit counter on each
//            increment strobe, then offers the digits over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module digit_inc_scheduler #(
  parameter int DIGITS = 8,
  parameter int BASE   = 10,
  parameter int DW     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc_stb,
  input  logic                 ref_stb,
  input  logic [DIGITS-1:0]    trigger,
  output logic [DIGITS*DW-1:0] digits,
  output logic                 upd_valid,
  input  logic                 upd_ready,
  output logic                 busy,
  output logic                 overflow,
  output logic                 missed
);

  localparam int             IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0]  c_LAST = IW'(DIGITS - 1);
  localparam logic [DW:0]    c_BASE = (DW + 1)'(BASE);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SCAN    = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_last;

  logic [DIGITS*DW-1:0]  r_digits;
  logic [DIGITS-1:0]     r_pend;
  logic [IW-1:0]         r_idx;
  logic                  r_carry;
  logic                  r_overflow;
  logic                  r_missed;

  logic [DW-1:0]         w_cur;
  logic [DW:0]           w_sum;
  logic                  w_wrap;
  logic [DW-1:0]         w_new;
  logic [DIGITS*DW-1:0]  w_digits_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // An increment with an empty mask falls through to the refresh check
        if (inc_stb && (|trigger)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SCAN;
        end else if (ref_stb) begin
          w_state_nxt = S_PUBLISH;
        end
      end
      S_SCAN: begin
        if (r_idx == c_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_PUBLISH;
        end
      end
      S_PUBLISH: begin
        if (upd_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cur        = r_digits[r_idx*DW +: DW];
    w_sum        = {1'b0, w_cur} + (DW + 1)'(r_pend[r_idx]) + (DW + 1)'(r_carry);
    w_wrap       = (w_sum >= c_BASE);
    w_new        = w_wrap ? DW'(w_sum - c_BASE) : DW'(w_sum);
    w_digits_nxt = r_digits;
    w_digits_nxt[r_idx*DW +: DW] = w_new;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_digits   <= '0;
      r_pend     <= '0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_missed   <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      r_missed   <= inc_stb && (r_state != S_IDLE);
      if (w_accept) begin
        r_pend  <= trigger;
        r_idx   <= '0;
        r_carry <= 1'b0;
      end
      if (r_state == S_SCAN) begin
        r_digits <= w_digits_nxt;
        r_carry  <= w_wrap;
        r_idx    <= w_last ? '0 : r_idx + IW'(1);
        if (w_last) begin
          r_overflow <= w_wrap;
        end
      end
    end
  end

  assign digits    = r_digits;
  assign upd_valid = (r_state == S_PUBLISH);
  assign busy      = (r_state != S_IDLE);
  assign overflow  = r_overflow;
  assign missed    = r_missed;

endmodule
`default_nettype wire
